// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_alu datapath: fixed widths, storage depths
// and the ALU opcode encoding. Imported by pipe_alu and pipe_alu_core.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int MEM_AW = 8;
  localparam int FUNC_W = 4;

  localparam int REG_N  = 1 << REG_AW;
  localparam int MEM_N  = 1 << MEM_AW;

  // Codes 12..15 are unassigned and produce a zero result.
  typedef enum logic [FUNC_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_SELA = 4'd3,
    OP_SELB = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NEGA = 4'd8,
    OP_NEGB = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLA  = 4'd11
  } alu_op_t;

endpackage

// File: rtl/pipe_alu_core.sv
// Combinational ALU for pipe_alu. All results wrap to DATA_W bits; no flags.
// Ports:
//   a, b : operands (DATA_W)
//   func : opcode (FUNC_W), see alu_op_t; unassigned codes give 0
//   y    : result (DATA_W)
module pipe_alu_core
  import pipe_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FUNC_W-1:0] func,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (func)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;          // keeps only the low DATA_W bits of the product
      OP_SELA: y = a;
      OP_SELB: y = b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NEGA: y = -a;
      OP_NEGB: y = -b;
      OP_SRA:  y = {1'b0, a[DATA_W-1:1]};  // logical: MSB refilled with 0
      OP_SLA:  y = {a[DATA_W-2:0], 1'b0};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pipe_alu.sv
// Four-stage register-to-register ALU pipeline with a 16-entry register bank
// and a 256-word data memory. One instruction is accepted on every rising
// edge; there is no forwarding, stalling or hazard detection.
//   edge k   : read regbank[rs1], regbank[rs2]; capture rd/func/addr
//   edge k+1 : Z <= alu(A, B, func)
//   edge k+2 : regbank[rd] <= Z
//   edge k+3 : mem[addr] <= result
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; flushes all pipeline state
//   Z     : stage-2 ALU result register (DATA_W)
//   rs1, rs2, rd : register indices (REG_AW)
//   func  : ALU opcode (FUNC_W)
//   addr  : memory store address (MEM_AW)
// regbank and mem are never reset so that preloaded contents survive reset.
module pipe_alu
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] Z,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [FUNC_W-1:0] func,
  input  logic [MEM_AW-1:0] addr
);

  logic [DATA_W-1:0] regbank [0:REG_N-1];
  logic [DATA_W-1:0] mem     [0:MEM_N-1];

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [REG_AW-1:0] rd_p0;
  logic [FUNC_W-1:0] func_p0;
  logic [MEM_AW-1:0] addr_p0;
  logic              vld_p0;

  logic [REG_AW-1:0] rd_p1;
  logic [MEM_AW-1:0] addr_p1;
  logic              vld_p1;

  logic [DATA_W-1:0] z_p2;
  logic [MEM_AW-1:0] addr_p2;
  logic              vld_p2;

  logic [DATA_W-1:0] alu_y;

  // Stage 1: operand read. A register written on this same edge by stage 3
  // is read with its old value, since both sides use nonblocking updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0    <= '0;
      b_p0    <= '0;
      rd_p0   <= '0;
      func_p0 <= '0;
      addr_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      a_p0    <= regbank[rs1];
      b_p0    <= regbank[rs2];
      rd_p0   <= rd;
      func_p0 <= func;
      addr_p0 <= addr;
      vld_p0  <= 1'b1;
    end
  end

  pipe_alu_core u_core (
    .a    (a_p0),
    .b    (b_p0),
    .func (func_p0),
    .y    (alu_y)
  );

  // Stage 2: compute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z       <= '0;
      rd_p1   <= '0;
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      Z       <= alu_y;
      rd_p1   <= rd_p0;
      addr_p1 <= addr_p0;
      vld_p1  <= vld_p0;
    end
  end

  // Stage 3: register write-back; result and address move on to the store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_p2    <= '0;
      addr_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      z_p2    <= Z;
      addr_p2 <= addr_p1;
      vld_p2  <= vld_p1;
    end
  end

  // Writes are gated by the propagated valid so that reset-flushed slots
  // never touch regbank[0] or mem[0].
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      regbank[rd_p1] <= Z;
    end
  end

  // Stage 4: memory store
  always_ff @(posedge clk) begin
    if (vld_p2) begin
      mem[addr_p2] <= z_p2;
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
module tb_pipe_alu;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] Z;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;

  pipe_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Z     (Z),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd    (rd),
    .func  (func),
    .addr  (addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural register file and memory, plus the list
  // of instructions still in flight with the number of edges since issue.
  logic [15:0] mreg [16];
  logic [15:0] mmem [256];
  typedef struct {
    logic [3:0]  rd;
    logic [7:0]  addr;
    logic [15:0] z;
    int          age;
  } inflight_t;
  inflight_t   q[$];
  logic [15:0] z_exp = 16'h0;

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input int f);
    int unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (f)
      0:  r = ua + ub;
      1:  r = ua - ub;
      2:  r = ua * ub;
      3:  r = ua;
      4:  r = ub;
      5:  r = ua & ub;
      6:  r = ua | ub;
      7:  r = ua ^ ub;
      8:  r = 0 - ua;
      9:  r = 0 - ub;
      10: r = ua / 2;
      11: r = ua * 2;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an instruction sees register state from before its
  // issue edge; it shows on Z one edge later, lands in the register file two
  // edges later and in memory three edges later. Reset drops everything.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      z_exp = 16'h0;
    end else begin
      inflight_t n;
      n.rd   = rd;
      n.addr = addr;
      n.z    = ref_alu(mreg[rs1], mreg[rs2], int'(func));
      n.age  = 0;
      for (int i = 0; i < q.size(); i++) begin
        q[i].age = q[i].age + 1;
        if (q[i].age == 1) z_exp = q[i].z;
        if (q[i].age == 2) mreg[q[i].rd] = q[i].z;
        if (q[i].age == 3) mmem[q[i].addr] = q[i].z;
      end
      while (q.size() > 0 && q[0].age >= 3) void'(q.pop_front());
      q.push_back(n);
    end
  end

  // Cycle-by-cycle comparison of Z and both storage arrays.
  initial begin
    int bad;
    forever begin
      @(negedge clk);
      check("Z", Z, z_exp);
      bad = -1;
      for (int i = 0; i < 16; i++) if (bad < 0 && dut.regbank[i] !== mreg[i]) bad = i;
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL regbank[%0d]: got %h expected %h", bad, dut.regbank[bad], mreg[bad]);
      end
      bad = -1;
      for (int i = 0; i < 256; i++) if (bad < 0 && dut.mem[i] !== mmem[i]) bad = i;
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL mem[%0d]: got %h expected %h", bad, dut.mem[bad], mmem[bad]);
      end
    end
  end

  task automatic issue(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] d,
                       input logic [3:0] f, input logic [7:0] ad);
    @(negedge clk);
    #1;
    rs1 = a1; rs2 = a2; rd = d; func = f; addr = ad;
  endtask

  // Filler instruction: zero result into r15 / mem[255].
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(4'd0, 4'd0, 4'd15, 4'd12, 8'd255);
  endtask

  task automatic poke_reg(input int i, input logic [15:0] v);
    dut.regbank[i] = v;
    mreg[i] = v;
  endtask

  logic [15:0] sweep_exp [16];

  initial begin
    rs1 = 0; rs2 = 0; rd = 4'd15; func = 4'd12; addr = 8'd255;
    for (int i = 0; i < 16; i++) poke_reg(i, 16'(i));
    for (int i = 0; i < 256; i++) begin
      dut.mem[i] = 16'hA000 + 16'(i);
      mmem[i]    = 16'hA000 + 16'(i);
    end
    #1 rst_n = 1'b0;
    #2 check("reset_Z", Z, 16'h0000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed sequence: back-to-back with no forwarding.
    issue(4'd3,  4'd5, 4'd10, 4'd0,  8'd125);   // ADD
    issue(4'd3,  4'd8, 4'd12, 4'd2,  8'd126);   // MUL
    issue(4'd10, 4'd5, 4'd14, 4'd1,  8'd128);   // SUB, old r10
    check("add_Z_latency", Z, 16'd8);
    issue(4'd7,  4'd0, 4'd13, 4'd11, 8'd127);   // SLA
    issue(4'd10, 4'd5, 4'd15, 4'd1,  8'd129);   // SUB, new r10
    issue(4'd12, 4'd13, 4'd0, 4'd0,  8'd130);   // ADD, old r13
    idle(4);
    check("regbank10", dut.regbank[10], 16'd8);
    check("mem125", dut.mem[125], 16'd8);
    check("mem126", dut.mem[126], 16'd24);
    check("mem127", dut.mem[127], 16'd14);
    check("mem128", dut.mem[128], 16'd5);
    check("mem129", dut.mem[129], 16'd3);
    check("mem130", dut.mem[130], 16'd37);

    // Every opcode on A=0x8001, B=0x0003.
    sweep_exp = '{16'h8004, 16'h7FFE, 16'h8003, 16'h8001, 16'h0003, 16'h0001,
                  16'h8003, 16'h8002, 16'h7FFF, 16'hFFFD, 16'h4000, 16'h0002,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    poke_reg(1, 16'h8001);
    poke_reg(2, 16'h0003);
    for (int f = 0; f < 16; f++) issue(4'd1, 4'd2, 4'd15, 4'(f), 8'(200 + f));
    idle(4);
    for (int f = 0; f < 16; f++) check($sformatf("func%0d", f), dut.mem[200 + f], sweep_exp[f]);

    // Wrap-around.
    poke_reg(3, 16'hFFFF);
    poke_reg(4, 16'h0001);
    poke_reg(5, 16'h0100);
    issue(4'd3, 4'd4, 4'd15, 4'd0, 8'd220);
    issue(4'd5, 4'd5, 4'd15, 4'd2, 8'd221);
    idle(4);
    check("add_wrap", dut.mem[220], 16'h0000);
    check("mul_wrap", dut.mem[221], 16'h0000);

    // Reset while an instruction sits between compute and write-back.
    issue(4'd1, 4'd2, 4'd9, 4'd0, 8'd150);
    idle(1);
    @(negedge clk);
    #1 check("z_before_rst", Z, 16'h8004);
    #1 rst_n = 1'b0;
    #1 check("rst_async_Z", Z, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    check("flushed_regbank9", dut.regbank[9], 16'd9);
    check("flushed_mem150", dut.mem[150], 16'hA096);

    // Held reset with a would-be write to r0 / mem[0] on the inputs.
    @(negedge clk);
    #1 rst_n = 1'b0;
    rs1 = 4'd1; rs2 = 4'd2; rd = 4'd0; func = 4'd0; addr = 8'd0;
    repeat (3) @(negedge clk);
    #1 check("held_rst_r0", dut.regbank[0], 16'd37);
    check("held_rst_mem0", dut.mem[0], 16'hA000);
    rd = 4'd15; func = 4'd12; addr = 8'd255;
    rst_n = 1'b1;
    idle(3);
    check("post_rst_r0", dut.regbank[0], 16'd37);
    check("post_rst_mem0", dut.mem[0], 16'hA000);

    // Randomized traffic with occasional register pokes and reset pulses.
    for (int i = 0; i < 16; i++) poke_reg(i, 16'($urandom));
    for (int c = 0; c < 400; c++) begin
      issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
      if ($urandom_range(0, 7) == 0) poke_reg(int'($urandom_range(0, 15)), 16'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
